switch_debouncer: RTL and testbench
===================================

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 Parameter DEBOUNCE_TICKS, default 8, meaning number of consecutive pulse_en ticks a raw level must hold before acceptance; legal range 1..(2^CNT_W)-1.
REQ-002 Parameter CNT_W, default 4, meaning width of each per-pin debounce counter.
REQ-003 Parameter SW_ACTIVE_LOW, default 0, meaning 1 = raw pin reads 0 when pressed (inverted at input).
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 clr_n  input  1  reset; asynchronous, active-low.
REQ-006 pulse_en  input  1  sampling tick, one clk wide; the same enable pulse the switch handler runs on.
REQ-007 raw_sw  input  3  raw switch pins; asynchronous to clk, bouncing.
REQ-008 sw_level  output  3  debounced, registered pressed level per pin (1 = pressed).
REQ-009 switches  output  3  one-hot press event vector for the downstream switch handler; 0 when no event.

Function
REQ-010 Each raw_sw bit SHALL pass through a 2-flop synchronizer (after optional inversion) before any other use; sync output = s[i].
REQ-011 Each pin SHALL run an independent FSM: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT; sw_level[i]=1 only in PRESSED and RELEASE_WAIT.
REQ-012 RELEASED -> PRESS_WAIT when s[i]=1; counter cleared on entry.
REQ-013 PRESS_WAIT: on pulse_en with s[i]=1 counter increments; on pulse_en with counter==DEBOUNCE_TICKS-1 and s[i]=1 -> PRESSED; s[i]=0 in any cycle -> RELEASED, counter cleared.
REQ-014 PRESSED -> RELEASE_WAIT when s[i]=0; counter cleared on entry.
REQ-015 RELEASE_WAIT: symmetric to PRESS_WAIT with s[i]=0 counting; acceptance -> RELEASED; s[i]=1 -> PRESSED, counter cleared.
REQ-016 Counter SHALL never wrap; it only counts in WAIT states and is cleared on every state change.
REQ-017 Ticks with pulse_en=0 SHALL not advance counters; bounce between ticks still aborts the WAIT state.
REQ-018 Latency: raw edge to s[i] = 2 clk; sw_level[i] rises on the clk edge of the DEBOUNCE_TICKS-th qualifying pulse_en tick.
REQ-019 Rising edge of sw_level[i] (registered edge detect) SHALL produce a press event: switches[i] high for exactly one clk, the cycle after sw_level[i] rises.
REQ-020 Release (falling sw_level) SHALL produce no event.
REQ-021 Simultaneous press events on multiple pins in the same cycle: switches SHALL carry only the lowest-index bit; higher-index events in that cycle are dropped, never queued.
REQ-022 switches SHALL always be 0 or one-hot; never multi-bit.
REQ-023 Holding a switch pressed SHALL generate one event only; a new event requires release acceptance then press acceptance.

Reset
REQ-024 clr_n=0 SHALL asynchronously clear synchronizer flops (to unpressed), counters, edge-detect flops, all FSMs to RELEASED, sw_level=3'b000, switches=3'b000.
REQ-025 Reset asserted mid-WAIT SHALL discard partial count; after clr_n rises, a switch still held SHALL be re-debounced from zero and then produce one event.
REQ-026 Reset deassertion SHALL be the only way to leave reset; no synchronous clear exists.

Verification
REQ-027 Clean press: DEBOUNCE_TICKS=8, pulse_en every 4 clk, raw_sw=3'b010 held -> sw_level=3'b010 at 8th tick after sync, switches=3'b010 for 1 clk, then 0 while held.
REQ-028 Bounce: raw_sw[0] toggles every 3 clk for 40 clk then holds 1 -> no event during bounce; one event 3'b001 after 8 stable ticks.
REQ-029 Simultaneous: raw_sw 0->3'b101 in one cycle -> sw_level=3'b101, switches=3'b001 for 1 clk, bit 2 event never emitted.
REQ-030 Release/re-press: press pin 2, release 8 ticks, re-press -> exactly two 3'b100 pulses; release glitch shorter than 8 ticks -> no second event.
REQ-031 Reset mid-operation: clr_n low at tick 5 of PRESS_WAIT with pin held -> outputs 0 immediately; after release of clr_n, event at 8 ticks + 2 clk sync later.
REQ-032 SW_ACTIVE_LOW=1: raw_sw=3'b111 idle, 3'b110 held -> event 3'b001 after 8 ticks.

Source files
------------

// File: rtl/switch_debouncer.sv
// Three-pin switch debouncer.
// Each raw pin is optionally inverted, passed through a 2-flop synchronizer and
// then qualified by a per-pin four-state FSM that only accepts a new level after
// DEBOUNCE_TICKS consecutive pulse_en ticks of agreement. Press acceptance is
// turned into a single-cycle, lowest-index-wins one-hot event for a downstream
// switch handler. Releases produce no event.
module switch_debouncer #(
  parameter int unsigned DEBOUNCE_TICKS = 8,
  parameter int unsigned CNT_W          = 4,
  parameter bit          SW_ACTIVE_LOW  = 1'b0
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       pulse_en,
  input  logic [2:0] raw_sw,
  output logic [2:0] sw_level,
  output logic [2:0] switches
);

  localparam int unsigned NumPins = 3;

  // Counter value seen on the tick that completes the debounce window.
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {
    StReleased    = 2'd0,
    StPressWait   = 2'd1,
    StPressed     = 2'd2,
    StReleaseWait = 2'd3
  } state_e;

  // Pressed-polarity view of the pins, before synchronization.
  logic [NumPins-1:0] raw_pressed;
  // First and second synchronizer stages; sync_out is the only consumer-facing copy.
  logic [NumPins-1:0] sync_meta;
  logic [NumPins-1:0] sync_out;
  // Edge-detect history and decoded press events.
  logic [NumPins-1:0] level_prev;
  logic [NumPins-1:0] level_rise;
  logic [NumPins-1:0] first_rise;

  assign raw_pressed = raw_sw ^ {NumPins{SW_ACTIVE_LOW}};

  // Two-flop synchronizer; resets to the unpressed level.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync_meta <= '0;
      sync_out  <= '0;
    end else begin
      sync_meta <= raw_pressed;
      sync_out  <= sync_meta;
    end
  end

  for (genvar i = 0; i < NumPins; i++) begin : g_pin
    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic             level;

    // Per-pin debounce FSM with registered level output.
    // Any disagreement sample aborts a WAIT state, tick or not; only ticks advance cnt.
    always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
        state <= StReleased;
        cnt   <= '0;
        level <= 1'b0;
      end else begin
        unique case (state)
          StReleased: begin
            if (sync_out[i]) begin
              state <= StPressWait;
              cnt   <= '0;
            end
          end
          StPressWait: begin
            if (!sync_out[i]) begin
              state <= StReleased;
              cnt   <= '0;
            end else if (pulse_en) begin
              if (cnt == LastCnt) begin
                state <= StPressed;
                cnt   <= '0;
                level <= 1'b1;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          StPressed: begin
            if (!sync_out[i]) begin
              state <= StReleaseWait;
              cnt   <= '0;
            end
          end
          StReleaseWait: begin
            if (sync_out[i]) begin
              state <= StPressed;
              cnt   <= '0;
            end else if (pulse_en) begin
              if (cnt == LastCnt) begin
                state <= StReleased;
                cnt   <= '0;
                level <= 1'b0;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          default: begin
            state <= StReleased;
            cnt   <= '0;
            level <= 1'b0;
          end
        endcase
      end
    end

    assign sw_level[i] = level;
  end

  // Rising level only; falling edges are deliberately ignored.
  assign level_rise = sw_level & ~level_prev;
  // Isolate lowest set bit so coincident presses collapse to one event.
  assign first_rise = level_rise & (~level_rise + 3'd1);

  // Edge-detect history and registered one-hot event output.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      level_prev <= '0;
      switches   <= '0;
    end else begin
      level_prev <= sw_level;
      switches   <= first_rise;
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Randomized plus directed bench for switch_debouncer with a queue scoreboard.
// The reference model tracks, per pin, how long the synchronized input has
// disagreed with the accepted level and counts qualifying ticks.
module tb_switch_debouncer;

  localparam int unsigned Ticks = 8;

  logic       clk;
  logic       clr_n;
  logic       pulse_en;
  logic [2:0] raw_sw;
  logic [2:0] raw_sw_n;
  logic [2:0] sw_level;
  logic [2:0] switches;
  logic [2:0] sw_level_al;
  logic [2:0] switches_al;

  assign raw_sw_n = ~raw_sw;

  switch_debouncer #(
    .DEBOUNCE_TICKS(Ticks),
    .CNT_W         (4),
    .SW_ACTIVE_LOW (1'b0)
  ) u_dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .pulse_en(pulse_en),
    .raw_sw  (raw_sw),
    .sw_level(sw_level),
    .switches(switches)
  );

  // Active-low copy fed the inverted pins; must behave identically.
  switch_debouncer #(
    .DEBOUNCE_TICKS(Ticks),
    .CNT_W         (4),
    .SW_ACTIVE_LOW (1'b1)
  ) u_dut_al (
    .clk     (clk),
    .clr_n   (clr_n),
    .pulse_en(pulse_en),
    .raw_sw  (raw_sw_n),
    .sw_level(sw_level_al),
    .switches(switches_al)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int unsigned cyc;
    logic [2:0]  val;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          ev_cnt = 0;
  int          ev_mark = 0;
  int          pper = 4;
  int          pcnt = 0;

  // Reference model state.
  logic [2:0] m_lvl = 3'b000;
  logic [2:0] m_wait = 3'b000;
  logic [2:0] sp1 = 3'b000;
  logic [2:0] sp2 = 3'b000;
  int         m_tk[3] = '{0, 0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model: a level is accepted after Ticks pulse_en ticks on which the synchronized
  // input already disagreed in the previous cycle; any agreement restarts the window.
  always @(posedge clk) begin
    logic [2:0] old_lvl;
    logic [2:0] rise;
    logic [2:0] pick;
    ev_t        e;
    cyc++;
    if (!clr_n) begin
      m_lvl  = 3'b000;
      m_wait = 3'b000;
      sp1    = 3'b000;
      sp2    = 3'b000;
      for (int i = 0; i < 3; i++) m_tk[i] = 0;
      exp_q.delete();
    end else begin
      old_lvl = m_lvl;
      for (int i = 0; i < 3; i++) begin
        if (sp2[i] == m_lvl[i]) begin
          m_wait[i] = 1'b0;
          m_tk[i]   = 0;
        end else if (!m_wait[i]) begin
          m_wait[i] = 1'b1;
          m_tk[i]   = 0;
        end else if (pulse_en) begin
          m_tk[i]++;
          if (m_tk[i] == int'(Ticks)) begin
            m_lvl[i]  = ~m_lvl[i];
            m_wait[i] = 1'b0;
            m_tk[i]   = 0;
          end
        end
      end
      rise = m_lvl & ~old_lvl;
      pick = 3'b000;
      for (int i = 2; i >= 0; i--) if (rise[i]) pick = 3'b001 << i;
      if (pick != 3'b000) begin
        e.cyc = cyc + 1;
        e.val = pick;
        exp_q.push_back(e);
      end
      sp2 = sp1;
      sp1 = raw_sw;
    end
  end

  // Monitor: pops expected events and compares both DUT copies every cycle.
  always @(negedge clk) begin
    logic [2:0] exp_sw;
    ev_t        e;
    if (!clr_n) begin
      check("reset_level", 32'(sw_level), 32'(0));
      check("reset_switches", 32'(switches), 32'(0));
      check("reset_level_al", 32'(sw_level_al), 32'(0));
    end else begin
      exp_sw = 3'b000;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        check("event_missed", 32'(0), 32'(e.val));
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        exp_sw = e.val;
      end
      check("switches", 32'(switches), 32'(exp_sw));
      check("switches_al", 32'(switches_al), 32'(exp_sw));
      check("sw_level", 32'(sw_level), 32'(m_lvl));
      check("sw_level_al", 32'(sw_level_al), 32'(m_lvl));
      check("onehot0", 32'($onehot0(switches)), 32'(1));
      if (switches != 3'b000) ev_cnt++;
    end
  end

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2;
      pcnt     = (pcnt + 1 >= pper) ? 0 : pcnt + 1;
      pulse_en = (pcnt == 0);
    end
  endtask

  task automatic expect_events(input string name, input int n);
    check(name, 32'(ev_cnt - ev_mark), 32'(n));
    ev_mark = ev_cnt;
  endtask

  initial begin
    int rate;
    clr_n    = 1'b1;
    raw_sw   = 3'b000;
    pulse_en = 1'b0;
    #1 clr_n = 1'b0;
    #1;
    check("async_reset_level", 32'(sw_level), 32'(0));
    check("async_reset_switches", 32'(switches), 32'(0));
    cycles(3);
    clr_n = 1'b1;
    cycles(5);
    ev_mark = ev_cnt;

    // Clean press of pin 1, held, then released.
    raw_sw = 3'b010;
    cycles(60);
    expect_events("clean_press_events", 1);
    raw_sw = 3'b000;
    cycles(50);
    expect_events("clean_release_events", 0);

    // Bounce on pin 0 then stable press.
    for (int k = 0; k < 13; k++) begin
      raw_sw[0] = ~raw_sw[0];
      cycles(3);
    end
    expect_events("bounce_no_event", 0);
    raw_sw = 3'b001;
    cycles(60);
    expect_events("bounce_settled_event", 1);
    raw_sw = 3'b000;
    cycles(50);

    // Simultaneous press of pins 0 and 2.
    raw_sw = 3'b101;
    cycles(60);
    expect_events("simultaneous_events", 1);
    raw_sw = 3'b000;
    cycles(50);

    // Press, full release, re-press, then a short release glitch.
    raw_sw = 3'b100;
    cycles(50);
    raw_sw = 3'b000;
    cycles(50);
    raw_sw = 3'b100;
    cycles(50);
    expect_events("repress_events", 2);
    raw_sw = 3'b000;
    cycles(10);
    raw_sw = 3'b100;
    cycles(50);
    expect_events("glitch_no_event", 0);
    raw_sw = 3'b000;
    cycles(50);

    // Reset in the middle of a press window, pin still held afterwards.
    pcnt   = 0;
    raw_sw = 3'b001;
    cycles(22);
    clr_n = 1'b0;
    cycles(3);
    clr_n = 1'b1;
    cycles(60);
    expect_events("reset_midwait_events", 1);
    raw_sw = 3'b000;
    cycles(50);

    // Randomized bouncing, tick periods and occasional resets.
    for (int seg = 0; seg < 8; seg++) begin
      pper = $urandom_range(1, 5);
      rate = $urandom_range(4, 60);
      for (int k = 0; k < 500; k++) begin
        if ($urandom_range(0, rate - 1) == 0) raw_sw[$urandom_range(0, 2)] ^= 1'b1;
        if ($urandom_range(0, 1499) == 0) begin
          clr_n = 1'b0;
          cycles($urandom_range(1, 3));
          clr_n = 1'b1;
        end
        cycles(1);
      end
    end

    pper   = 4;
    raw_sw = 3'b000;
    cycles(80);
    check("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
